// File: rtl/maq_regressiva.sv
// MM:SS countdown timer with BCD digits, preset load with validity check,
// start/pause control and a latched alarm once the count reaches 00:00.
module maq_regressiva #(
  localparam int unsigned MSD_W = 3,
  localparam int unsigned LSD_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable1hz,
  input  logic             load,
  input  logic [MSD_W-1:0] preset_m_msd,
  input  logic [LSD_W-1:0] preset_m_lsd,
  input  logic [MSD_W-1:0] preset_s_msd,
  input  logic [LSD_W-1:0] preset_s_lsd,
  input  logic             start,
  input  logic             pause,
  output logic [MSD_W-1:0] bcd_m_msd,
  output logic [LSD_W-1:0] bcd_m_lsd,
  output logic [MSD_W-1:0] bcd_s_msd,
  output logic [LSD_W-1:0] bcd_s_lsd,
  output logic             running,
  output logic             fim,
  output logic             alarme,
  output logic             erro_preset
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [MSD_W-1:0] m_msd_q, m_msd_d, s_msd_q, s_msd_d;
  logic [LSD_W-1:0] m_lsd_q, m_lsd_d, s_lsd_q, s_lsd_d;
  logic             fim_q, fim_d, erro_q, erro_d, running_q, alarme_q;

  logic [MSD_W-1:0] dec_m_msd, dec_s_msd;
  logic [LSD_W-1:0] dec_m_lsd, dec_s_lsd;
  logic             dec_zero, count_zero, preset_ok;

  // One-second BCD decrement with borrow from seconds into minutes
  always_comb begin
    dec_m_msd = m_msd_q;
    dec_m_lsd = m_lsd_q;
    dec_s_msd = s_msd_q;
    dec_s_lsd = s_lsd_q - LSD_W'(1);
    if (s_lsd_q == LSD_W'(0)) begin
      dec_s_lsd = LSD_W'(9);
      if (s_msd_q != MSD_W'(0)) begin
        dec_s_msd = s_msd_q - MSD_W'(1);
      end else begin
        dec_s_msd = MSD_W'(5);
        if (m_lsd_q != LSD_W'(0)) begin
          dec_m_lsd = m_lsd_q - LSD_W'(1);
        end else begin
          dec_m_lsd = LSD_W'(9);
          dec_m_msd = m_msd_q - MSD_W'(1);
        end
      end
    end
    dec_zero = (dec_m_msd == MSD_W'(0)) && (dec_m_lsd == LSD_W'(0)) &&
               (dec_s_msd == MSD_W'(0)) && (dec_s_lsd == LSD_W'(0));
  end

  assign count_zero = (m_msd_q == MSD_W'(0)) && (m_lsd_q == LSD_W'(0)) &&
                      (s_msd_q == MSD_W'(0)) && (s_lsd_q == LSD_W'(0));
  assign preset_ok  = (preset_m_msd <= MSD_W'(5)) && (preset_m_lsd <= LSD_W'(9)) &&
                      (preset_s_msd <= MSD_W'(5)) && (preset_s_lsd <= LSD_W'(9));

  // Next state: the first input that actually acts this cycle wins
  always_comb begin
    state_d = state_q;
    m_msd_d = m_msd_q;
    m_lsd_d = m_lsd_q;
    s_msd_d = s_msd_q;
    s_lsd_d = s_lsd_q;
    fim_d   = 1'b0;
    erro_d  = 1'b0;
    if (load) begin
      if (preset_ok) begin
        state_d = S_IDLE;
        m_msd_d = preset_m_msd;
        m_lsd_d = preset_m_lsd;
        s_msd_d = preset_s_msd;
        s_lsd_d = preset_s_lsd;
      end else begin
        erro_d = 1'b1;
      end
    end else if (pause && (state_q == S_RUN || state_q == S_DONE)) begin
      if (state_q == S_RUN) begin
        state_d = S_PAUSE;
      end else begin
        state_d = S_IDLE;
        m_msd_d = MSD_W'(0);
        m_lsd_d = LSD_W'(0);
        s_msd_d = MSD_W'(0);
        s_lsd_d = LSD_W'(0);
      end
    end else if (start && (state_q == S_IDLE || state_q == S_PAUSE) && !count_zero) begin
      state_d = S_RUN;
    end else if (enable1hz && state_q == S_RUN) begin
      m_msd_d = dec_m_msd;
      m_lsd_d = dec_m_lsd;
      s_msd_d = dec_s_msd;
      s_lsd_d = dec_s_lsd;
      if (dec_zero) begin
        state_d = S_DONE;
        fim_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      m_msd_q   <= MSD_W'(0);
      m_lsd_q   <= LSD_W'(0);
      s_msd_q   <= MSD_W'(0);
      s_lsd_q   <= LSD_W'(0);
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
      running_q <= 1'b0;
      alarme_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_msd_q   <= m_msd_d;
      m_lsd_q   <= m_lsd_d;
      s_msd_q   <= s_msd_d;
      s_lsd_q   <= s_lsd_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
      running_q <= (state_d == S_RUN);
      alarme_q  <= (state_d == S_DONE);
    end
  end

  assign bcd_m_msd   = m_msd_q;
  assign bcd_m_lsd   = m_lsd_q;
  assign bcd_s_msd   = s_msd_q;
  assign bcd_s_lsd   = s_lsd_q;
  assign running     = running_q;
  assign fim         = fim_q;
  assign alarme      = alarme_q;
  assign erro_preset = erro_q;

endmodule

// File: tb/tb_maq_regressiva.sv
// Bench for maq_regressiva: directed scenarios with fixed expectations plus a
// random run compared against a seconds-based behavioural model.
module tb_maq_regressiva;

  logic       clock = 1'b0;
  logic       reset = 1'b0, enable1hz = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [2:0] preset_m_msd = '0, preset_s_msd = '0;
  logic [3:0] preset_m_lsd = '0, preset_s_lsd = '0;
  logic [2:0] bcd_m_msd, bcd_s_msd;
  logic [3:0] bcd_m_lsd, bcd_s_lsd;
  logic       running, fim, alarme, erro_preset;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: total seconds remaining plus a mode number (0 idle,1 run,2 pause,3 done)
  int mdl_secs = 0;
  int mdl_mode = 0;
  bit mdl_fim  = 0;
  bit mdl_err  = 0;

  maq_regressiva dut (
    .clock(clock), .reset(reset), .enable1hz(enable1hz), .load(load),
    .preset_m_msd(preset_m_msd), .preset_m_lsd(preset_m_lsd),
    .preset_s_msd(preset_s_msd), .preset_s_lsd(preset_s_lsd),
    .start(start), .pause(pause),
    .bcd_m_msd(bcd_m_msd), .bcd_m_lsd(bcd_m_lsd),
    .bcd_s_msd(bcd_s_msd), .bcd_s_lsd(bcd_s_lsd),
    .running(running), .fim(fim), .alarme(alarme), .erro_preset(erro_preset)
  );

  always #5 clock = ~clock;

  logic [17:0] dut_vec;
  assign dut_vec = {bcd_m_msd, bcd_m_lsd, bcd_s_msd, bcd_s_lsd, running, fim, alarme, erro_preset};

  function automatic logic [17:0] pack(int mm, int ss, bit run, bit f, bit al, bit er);
    logic [2:0] a, c;
    logic [3:0] b, d;
    a = 3'(mm / 10); b = 4'(mm % 10); c = 3'(ss / 10); d = 4'(ss % 10);
    return {a, b, c, d, run, f, al, er};
  endfunction

  function automatic logic [17:0] model_vec();
    return pack(mdl_secs / 60, mdl_secs % 60, mdl_mode == 1, mdl_fim, mdl_mode == 3, mdl_err);
  endfunction

  task automatic model_update();
    bit ok;
    mdl_fim = 0;
    mdl_err = 0;
    ok = (preset_m_msd <= 5) && (preset_m_lsd <= 9) && (preset_s_msd <= 5) && (preset_s_lsd <= 9);
    if (reset) begin
      mdl_secs = 0; mdl_mode = 0;
    end else if (load) begin
      if (ok) begin
        mdl_secs = (int'(preset_m_msd) * 10 + int'(preset_m_lsd)) * 60 +
                   int'(preset_s_msd) * 10 + int'(preset_s_lsd);
        mdl_mode = 0;
      end else mdl_err = 1;
    end else if (pause && mdl_mode == 1) begin
      mdl_mode = 2;
    end else if (pause && mdl_mode == 3) begin
      mdl_mode = 0; mdl_secs = 0;
    end else if (start && (mdl_mode == 0 || mdl_mode == 2) && mdl_secs != 0) begin
      mdl_mode = 1;
    end else if (enable1hz && mdl_mode == 1) begin
      mdl_secs = mdl_secs - 1;
      if (mdl_secs == 0) begin
        mdl_mode = 3; mdl_fim = 1;
      end
    end
  endtask

  // One clock: model consumes the driven inputs, outputs sampled 1ns after the edge
  task automatic clk_step();
    model_update();
    @(posedge clock);
    #1;
    reset = 0; load = 0; start = 0; pause = 0; enable1hz = 0;
  endtask

  task automatic set_preset(int mm, int ss);
    preset_m_msd = 3'(mm / 10); preset_m_lsd = 4'(mm % 10);
    preset_s_msd = 3'(ss / 10); preset_s_lsd = 4'(ss % 10);
  endtask

  task automatic do_load(int mm, int ss);
    set_preset(mm, ss); load = 1; clk_step();
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    reset = 1; clk_step();
    exp = pack(0, 0, 0, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL reset_initial got=%h exp=%h", dut_vec, exp); end
    do_load(1, 30); start = 1; clk_step(); enable1hz = 1; clk_step();
    exp = pack(1, 29, 1, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL reset_run_0129 got=%h exp=%h", dut_vec, exp); end
    reset = 1; enable1hz = 1; start = 1; clk_step();
    exp = pack(0, 0, 0, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL reset_from_run got=%h exp=%h", dut_vec, exp); end
    for (int i = 0; i < 3; i++) begin enable1hz = 1; clk_step(); end
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL reset_ticks_idle got=%h exp=%h", dut_vec, exp); end
    do_load(0, 1); start = 1; clk_step(); enable1hz = 1; clk_step();
    reset = 1; pause = 1; clk_step();
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL reset_from_done got=%h exp=%h", dut_vec, exp); end
  endtask

  task automatic test_borrow();
    logic [17:0] exp;
    do_load(10, 0); start = 1; clk_step(); enable1hz = 1; clk_step();
    exp = pack(9, 59, 1, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL borrow_1000 got=%h exp=%h", dut_vec, exp); end
    do_load(1, 0); start = 1; clk_step(); enable1hz = 1; clk_step();
    exp = pack(0, 59, 1, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL borrow_0100 got=%h exp=%h", dut_vec, exp); end
    do_load(0, 20); start = 1; clk_step(); enable1hz = 1; clk_step();
    exp = pack(0, 19, 1, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL borrow_0020 got=%h exp=%h", dut_vec, exp); end
  endtask

  task automatic test_terminal();
    logic [17:0] exp;
    do_load(0, 2); start = 1; clk_step();
    enable1hz = 1; clk_step();
    exp = pack(0, 1, 1, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL term_0001 got=%h exp=%h", dut_vec, exp); end
    enable1hz = 1; clk_step();
    exp = pack(0, 0, 0, 1, 1, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL term_fim got=%h exp=%h", dut_vec, exp); end
    clk_step();
    exp = pack(0, 0, 0, 0, 1, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL term_fim_single got=%h exp=%h", dut_vec, exp); end
    enable1hz = 1; clk_step(); start = 1; clk_step(); start = 1; enable1hz = 1; clk_step();
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL term_hold got=%h exp=%h", dut_vec, exp); end
    pause = 1; clk_step();
    exp = pack(0, 0, 0, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL term_ack got=%h exp=%h", dut_vec, exp); end
  endtask

  task automatic test_invalid_preset();
    logic [17:0] exp;
    do_load(0, 45);
    preset_m_msd = 0; preset_m_lsd = 0; preset_s_msd = 3'd6; preset_s_lsd = 0; load = 1; clk_step();
    exp = pack(0, 45, 0, 0, 0, 1);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL inval_s_msd got=%h exp=%h", dut_vec, exp); end
    clk_step();
    exp = pack(0, 45, 0, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL inval_pulse_single got=%h exp=%h", dut_vec, exp); end
    start = 1; clk_step();
    preset_m_msd = 0; preset_m_lsd = 4'd10; preset_s_msd = 0; preset_s_lsd = 0; load = 1; clk_step();
    exp = pack(0, 45, 1, 0, 0, 1);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL inval_m_lsd_run got=%h exp=%h", dut_vec, exp); end
  endtask

  task automatic test_simultaneous();
    logic [17:0] exp;
    do_load(0, 11); start = 1; clk_step(); enable1hz = 1; clk_step();
    pause = 1; enable1hz = 1; clk_step();
    exp = pack(0, 10, 0, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL sim_pause_tick got=%h exp=%h", dut_vec, exp); end
    start = 1; enable1hz = 1; clk_step();
    exp = pack(0, 10, 1, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL sim_start_tick got=%h exp=%h", dut_vec, exp); end
    enable1hz = 1; clk_step();
    exp = pack(0, 9, 1, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL sim_next_tick got=%h exp=%h", dut_vec, exp); end
    set_preset(0, 5); load = 1; start = 1; clk_step();
    exp = pack(0, 5, 0, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL sim_load_start got=%h exp=%h", dut_vec, exp); end
  endtask

  task automatic test_zero_start();
    logic [17:0] exp;
    int fim_seen;
    reset = 1; clk_step();
    fim_seen = 0;
    for (int i = 0; i < 4; i++) begin
      start = 1; enable1hz = (i % 2 == 1); clk_step();
      if (fim === 1'b1) fim_seen++;
    end
    exp = pack(0, 0, 0, 0, 0, 0);
    n_tests++; if (dut_vec !== exp) begin n_fail++; $display("FAIL zero_start got=%h exp=%h", dut_vec, exp); end
    n_tests++; if (fim_seen != 0) begin n_fail++; $display("FAIL zero_start_fim got=%0d exp=0", fim_seen); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    reset = 1; clk_step();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      load      = ($urandom_range(0, 99) < 5);
      pause     = ($urandom_range(0, 99) < 6);
      start     = ($urandom_range(0, 99) < 15);
      enable1hz = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 3) == 0) begin
        preset_m_msd = 3'($urandom_range(0, 7)); preset_m_lsd = 4'($urandom_range(0, 15));
        preset_s_msd = 3'($urandom_range(0, 7)); preset_s_lsd = 4'($urandom_range(0, 15));
      end else begin
        preset_m_msd = 0; preset_m_lsd = 4'($urandom_range(0, 1));
        preset_s_msd = 3'($urandom_range(0, 2)); preset_s_lsd = 4'($urandom_range(0, 9));
      end
      clk_step();
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        if (errs < 10) $display("FAIL random_cycle_%0d got=%h exp=%h", i, dut_vec, model_vec());
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_terminal();
    test_invalid_preset();
    test_simultaneous();
    test_zero_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maq_regressiva.md
MAQ_REGRESSIVA -- requirements
Module: maq_regressiva

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning); clock and reset: reset reset, synchronous, active-high; clock clock.
  - clock  in  1  system clock; all state changes on posedge.
  - reset  in  1  synchronous, active-high.
  - enable1hz  in  1  one-cycle tick, once per second.
  - load  in  1  load-preset strobe.
  - preset_m_msd  in  3  preset minutes tens.
  - preset_m_lsd  in  4  preset minutes units.
  - preset_s_msd  in  3  preset seconds tens.
  - preset_s_lsd  in  4  preset seconds units.
  - start  in  1  start/resume strobe.
  - pause  in  1  pause strobe; also alarm acknowledge.
  - bcd_m_msd  out  3  count minutes tens.
  - bcd_m_lsd  out  4  count minutes units.
  - bcd_s_msd  out  3  count seconds tens.
  - bcd_s_lsd  out  4  count seconds units.
  - running  out  1  high while in RUN.
  - fim  out  1  one-cycle pulse on reaching 00:00.
  - alarme  out  1  level, high while in DONE.
  - erro_preset  out  1  one-cycle pulse on rejected load.
REQ-002 All outputs SHALL be registered.

Function
REQ-003 States SHALL be IDLE, RUN, PAUSE and DONE.
REQ-004 The count range SHALL be 00:00..59:59.
  - lsd digits 0..9; msd digits 0..5; values stay valid BCD at all times.
REQ-005 A preset SHALL be valid iff both msd <= 5 and both lsd <= 9.
REQ-006 load with a valid preset SHALL, on that edge, copy the preset to the count and enter IDLE, from any state.
  - Clears alarme.
REQ-007 load with an invalid preset SHALL leave count and state unchanged and pulse erro_preset high for exactly one cycle.
REQ-008 Input priority per cycle SHALL be load > pause > start > enable1hz.
  - Lower-priority inputs are ignored in any cycle where a higher one acts.
REQ-009 start in IDLE or PAUSE with count != 00:00 SHALL enter RUN.
  - start with count == 00:00 is ignored: no fim, no state change.
  - start in RUN or DONE is ignored.
REQ-010 pause in RUN SHALL enter PAUSE with the count frozen.
  - pause in DONE enters IDLE with count 00:00 and clears alarme.
  - pause in IDLE or PAUSE is ignored.
REQ-011 enable1hz in RUN, with no higher-priority input that cycle, SHALL decrement the count by one second, effective on the same edge.
  - s_lsd > 0: s_lsd - 1.
  - s_lsd = 0, s_msd > 0: s_lsd = 9, s_msd - 1.
  - Seconds = 00: seconds = 59; minutes decremented with the same lsd/msd borrow rule.
REQ-012 The decrement that yields 00:00 SHALL, on that same edge, enter DONE and set fim for exactly one cycle.
  - alarme is 1 from that edge on.
REQ-013 In IDLE, PAUSE and DONE, enable1hz SHALL have no effect on count.
  - The tick arriving in the same cycle as an accepted start is not applied; the first decrement occurs on the next tick.
REQ-014 running SHALL be 1 iff state == RUN.
  - alarme SHALL be 1 iff state == DONE.
REQ-015 fim and erro_preset SHALL be 0 in every cycle not named in REQ-007 and REQ-012.

Reset
REQ-016 reset SHALL take priority over all other inputs.
  - Sets count 00:00, state IDLE, and running, fim, alarme, erro_preset all 0.
REQ-017 reset asserted during RUN, PAUSE or DONE SHALL produce the REQ-016 state on the next edge, with no fim pulse.

Verification
REQ-018 Reset: run a 01:30 count, assert reset -> next cycle count 00:00, IDLE, all flags 0; ticks cause no change.
REQ-019 Borrow chain: load 10:00, start, one tick -> 09:59; load 01:00, start, one tick -> 00:59.
REQ-020 Terminal count: load 00:02, start, two ticks.
  - After the ticks: 00:01, then 00:00 with fim high for exactly 1 cycle, alarme = 1, running = 0.
  - Further ticks and start: no change.
  - pause: IDLE, alarme = 0.
REQ-021 Invalid preset: from count 00:45, load with preset_s_msd = 6 (or preset_m_lsd = 10) -> erro_preset 1 for one cycle, count stays 00:45, state unchanged.
REQ-022 Simultaneity:
  - In RUN at 00:10, pause + tick in the same cycle -> PAUSE, count 00:10.
  - start + tick -> RUN, count 00:10; next tick -> 00:09.
  - load 00:05 + start in the same cycle -> count 00:05, IDLE.
REQ-023 Zero start: after reset (00:00), start -> remains IDLE, fim never pulses.
